// File: rtl/sw_serial_in_pkg.sv
// rtl/sw_serial_in_pkg.sv - shared serial I/O constants and scan FSM encoding
package sw_serial_in_pkg;

   localparam int SW_WIDTH_DEF = 16;
   localparam int SW_DIV_DEF   = 4;

   // The serial-output LED driver runs its shift clock off the same divider.
   localparam int LED_WIDTH_DEF = 16;
   localparam int LED_DIV_DEF   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_DONE
   } scan_state_e;

endpackage

// File: rtl/sw_serial_in_if.sv
// rtl/sw_serial_in_if.sv - pins to the external parallel-in/serial-out register
interface sw_serial_in_if;

   logic sw_sin;
   logic sw_load_n;
   logic sw_clk;
   logic sw_ce_n;

   modport master (input sw_sin, output sw_load_n, output sw_clk, output sw_ce_n);
   modport slave  (output sw_sin, input sw_load_n, input sw_clk, input sw_ce_n);

endinterface

// File: rtl/spio_tick.sv
// rtl/spio_tick.sv - one-cycle tick every DIV clocks, restartable with clr
module spio_tick
   import sw_serial_in_pkg::*;
#(
   parameter int DIV = SW_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sw_serial_in_core.sv
// rtl/sw_serial_in_core.sv - scan FSM: load, shift WIDTH bits MSB first, publish
module sw_serial_in_core
   import sw_serial_in_pkg::*;
#(
   parameter int WIDTH = SW_WIDTH_DEF,
   parameter int DIV   = SW_DIV_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 en_i,
   sw_serial_in_if.master       bus,
   output logic                 busy_o,
   output logic                 rdy_o,
   output logic [WIDTH-1:0]     p_out_o
);

   localparam int            BW   = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] BITS = BW'(WIDTH);

   scan_state_e      state_q;
   logic [WIDTH-1:0] shift_q, p_out_q;
   logic [BW-1:0]    bit_cnt_q;
   logic             load_n_q, sclk_q, ce_n_q, busy_q, rdy_q;
   logic             tick, tick_clr;

   // Timed states only leave on tick, which already restarts the divider.
   assign tick_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

   spio_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (tick_clr),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         p_out_q   <= '0;
         bit_cnt_q <= '0;
         load_n_q  <= 1'b1;
         sclk_q    <= 1'b0;
         ce_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start_i) begin
               state_q  <= ST_LOAD;
               load_n_q <= 1'b0;
               busy_q   <= 1'b1;
            end
            ST_LOAD: if (tick) begin
               state_q   <= ST_SHIFT_LO;
               bit_cnt_q <= '0;
               load_n_q  <= 1'b1;
               ce_n_q    <= 1'b0;
            end
            ST_SHIFT_LO: if (tick) begin
               state_q <= ST_SHIFT_HI;
               shift_q <= WIDTH'({shift_q, bus.sw_sin});
               sclk_q  <= 1'b1;
            end
            ST_SHIFT_HI: if (tick) begin
               sclk_q    <= 1'b0;
               bit_cnt_q <= bit_cnt_q + BW'(1);
               if (bit_cnt_q == BITS - BW'(1)) begin
                  state_q <= ST_DONE;
                  ce_n_q  <= 1'b1;
                  rdy_q   <= 1'b1;
                  p_out_q <= shift_q;
               end else begin
                  state_q <= ST_SHIFT_LO;
               end
            end
            ST_DONE: begin
               if (en_i) begin
                  state_q  <= ST_LOAD;
                  load_n_q <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.sw_load_n = load_n_q;
   assign bus.sw_clk    = sclk_q;
   assign bus.sw_ce_n   = ce_n_q;
   assign busy_o        = busy_q;
   assign rdy_o         = rdy_q;
   assign p_out_o       = p_out_q;

endmodule

// File: rtl/sw_serial_in.sv
// rtl/sw_serial_in.sv - serial switch-bank reader, top level
module sw_serial_in
   import sw_serial_in_pkg::*;
#(
   parameter int WIDTH = SW_WIDTH_DEF,
   parameter int DIV   = SW_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             EN,
   input  logic             sw_sin,
   output logic             sw_load_n,
   output logic             sw_clk,
   output logic             sw_ce_n,
   output logic             busy,
   output logic             rdy,
   output logic [WIDTH-1:0] P_out
);

   sw_serial_in_if bus ();

   assign bus.sw_sin = sw_sin;
   assign sw_load_n  = bus.sw_load_n;
   assign sw_clk     = bus.sw_clk;
   assign sw_ce_n    = bus.sw_ce_n;

   sw_serial_in_core #(.WIDTH(WIDTH), .DIV(DIV)) u_core (
      .clk     (clk),
      .rst     (rst),
      .start_i (Start),
      .en_i    (EN),
      .bus     (bus.master),
      .busy_o  (busy),
      .rdy_o   (rdy),
      .p_out_o (P_out)
   );

endmodule

// File: tb/tb_sw_serial_in.sv
// tb/tb_sw_serial_in.sv - scoreboard bench for sw_serial_in, default and wide builds
`timescale 1ns/1ps
module tb_sw_serial_in;

   localparam int W1 = 16, D1 = 4, W2 = 32, D2 = 2;
   localparam int LAT1 = D1 * (2 * W1 + 1);
   localparam int LAT2 = D2 * (2 * W2 + 1);

   typedef struct {
      logic [31:0] val;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic start1 = 1'b0, en1 = 1'b0, start2 = 1'b0, en2 = 1'b0;
   logic busy1, rdy1, busy2, rdy2;
   logic [W1-1:0] pout1;
   logic [W2-1:0] pout2;
   exp_t exp1_q[$], exp2_q[$];

   sw_serial_in_if bus1 ();
   sw_serial_in_if bus2 ();

   sw_serial_in #(.WIDTH(W1), .DIV(D1)) dut1 (
      .clk(clk), .rst(rst), .Start(start1), .EN(en1), .sw_sin(bus1.sw_sin),
      .sw_load_n(bus1.sw_load_n), .sw_clk(bus1.sw_clk), .sw_ce_n(bus1.sw_ce_n),
      .busy(busy1), .rdy(rdy1), .P_out(pout1));

   sw_serial_in #(.WIDTH(W2), .DIV(D2)) dut2 (
      .clk(clk), .rst(rst), .Start(start2), .EN(en2), .sw_sin(bus2.sw_sin),
      .sw_load_n(bus2.sw_load_n), .sw_clk(bus2.sw_clk), .sw_ce_n(bus2.sw_ce_n),
      .busy(busy2), .rdy(rdy2), .P_out(pout2));

   // External 165-style registers: load while load_n low, shift on sw_clk rise.
   logic [W1-1:0] model1_val = '0, model1_sr = '0;
   logic [W2-1:0] model2_val = '0, model2_sr = '0;
   logic model1_prev = 1'b0, model2_prev = 1'b0;
   int clk_rises1 = 0, load_low1 = 0, clk_rises2 = 0;
   assign bus1.sw_sin = model1_sr[W1-1];
   assign bus2.sw_sin = model2_sr[W2-1];

   always @(posedge clk) begin
      model1_prev <= bus1.sw_clk;
      if (bus1.sw_clk && !model1_prev) clk_rises1 <= clk_rises1 + 1;
      if (!bus1.sw_load_n) begin
         model1_sr <= model1_val;
         load_low1 <= load_low1 + 1;
      end else if (!bus1.sw_ce_n && bus1.sw_clk && !model1_prev)
         model1_sr <= {model1_sr[W1-2:0], 1'b0};
   end

   always @(posedge clk) begin
      model2_prev <= bus2.sw_clk;
      if (bus2.sw_clk && !model2_prev) clk_rises2 <= clk_rises2 + 1;
      if (!bus2.sw_load_n) model2_sr <= model2_val;
      else if (!bus2.sw_ce_n && bus2.sw_clk && !model2_prev)
         model2_sr <= {model2_sr[W2-2:0], 1'b0};
   end

   int rdy_cnt1 = 0, rdy_cnt2 = 0;
   logic [W1-1:0] hold1 = '0;
   logic [W2-1:0] hold2 = '0;

   always @(negedge clk) begin : mon1
      exp_t e;
      if (!rst) hold1 = '0;
      vectors++;
      if (rdy1) begin
         rdy_cnt1++;
         if (exp1_q.size() == 0) begin
            errors++;
            $display("FAIL scan1_unexpected: P_out=%h at cycle %0d, no scan expected", pout1, cyc);
         end else begin
            e = exp1_q.pop_front();
            if (pout1 !== e.val[W1-1:0] || cyc != e.cyc) begin
               errors++;
               $display("FAIL scan1: P_out=%h cycle=%0d, required P_out=%h cycle=%0d",
                        pout1, cyc, e.val[W1-1:0], e.cyc);
            end
         end
         hold1 = pout1;
      end else if (pout1 !== hold1) begin
         errors++;
         $display("FAIL pout1_hold: P_out=%h, required %h", pout1, hold1);
      end
      vectors++;
      if (!bus1.sw_load_n && !bus1.sw_ce_n) begin
         errors++;
         $display("FAIL overlap1: load_n=0 ce_n=0 at cycle %0d, required never both low", cyc);
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (!rst) hold2 = '0;
      vectors++;
      if (rdy2) begin
         rdy_cnt2++;
         if (exp2_q.size() == 0) begin
            errors++;
            $display("FAIL scan2_unexpected: P_out=%h at cycle %0d, no scan expected", pout2, cyc);
         end else begin
            e = exp2_q.pop_front();
            if (pout2 !== e.val || cyc != e.cyc) begin
               errors++;
               $display("FAIL scan2: P_out=%h cycle=%0d, required P_out=%h cycle=%0d",
                        pout2, cyc, e.val, e.cyc);
            end
         end
         hold2 = pout2;
      end else if (pout2 !== hold2) begin
         errors++;
         $display("FAIL pout2_hold: P_out=%h, required %h", pout2, hold2);
      end
      vectors++;
      if (!bus2.sw_load_n && !bus2.sw_ce_n) begin
         errors++;
         $display("FAIL overlap2: load_n=0 ce_n=0 at cycle %0d, required never both low", cyc);
      end
   end

   task automatic wait_rdy(input int which, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if ((which == 1) ? rdy1 : rdy2) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus1.sw_load_n, bus1.sw_clk, bus1.sw_ce_n, busy1, rdy1} !== 5'b10100) begin
         errors++;
         $display("FAIL reset1_ctrl: load_n,clk,ce_n,busy,rdy=%b, required 10100",
                  {bus1.sw_load_n, bus1.sw_clk, bus1.sw_ce_n, busy1, rdy1});
      end
      vectors++;
      if ({bus2.sw_load_n, bus2.sw_clk, bus2.sw_ce_n, busy2, rdy2} !== 5'b10100) begin
         errors++;
         $display("FAIL reset2_ctrl: load_n,clk,ce_n,busy,rdy=%b, required 10100",
                  {bus2.sw_load_n, bus2.sw_clk, bus2.sw_ce_n, busy2, rdy2});
      end
      vectors++;
      if (pout1 !== '0 || pout2 !== '0) begin
         errors++;
         $display("FAIL reset_pout: P_out1=%h P_out2=%h, required 0", pout1, pout2);
      end
      rst = 1'b1;
   endtask

   // Start is raised in the same instant reset releases: first edge must honour it.
   task automatic test_single;
      int t, rises0, low0;
      bit seen;
      model1_val = 16'hA5C3;
      rises0 = clk_rises1;
      low0 = load_low1;
      start1 = 1'b1;
      t = cyc;
      exp1_q.push_back('{32'h0000_A5C3, t + 1 + LAT1});
      @(negedge clk);
      start1 = 1'b0;
      wait_rdy(1, LAT1 + 10, seen);
      vectors++;
      if (!seen) begin
         errors++;
         $display("FAIL single_timeout: rdy not seen, required within %0d cycles", LAT1 + 10);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (clk_rises1 - rises0 != W1) begin
         errors++;
         $display("FAIL single_sw_clk: %0d rises, required %0d", clk_rises1 - rises0, W1);
      end
      vectors++;
      if (load_low1 - low0 != D1) begin
         errors++;
         $display("FAIL single_load_n: low %0d cycles, required %0d", load_low1 - low0, D1);
      end
   endtask

   task automatic test_ignore_start;
      int t, r0;
      bit seen;
      @(negedge clk);
      model1_val = 16'h3C96;
      r0 = rdy_cnt1;
      start1 = 1'b1;
      t = cyc;
      exp1_q.push_back('{32'h0000_3C96, t + 1 + LAT1});
      @(negedge clk);
      start1 = 1'b0;
      repeat (49) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_rdy(1, LAT1, seen);
      repeat (20) @(negedge clk);
      vectors++;
      if (rdy_cnt1 - r0 != 1 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: %0d rdy pulses busy=%b, required 1 pulse busy=0",
                  rdy_cnt1 - r0, busy1);
      end
   endtask

   task automatic test_continuous;
      int t, r0, drops;
      bit seen;
      @(negedge clk);
      model1_val = 16'hA5C3;
      r0 = rdy_cnt1;
      en1 = 1'b1;
      start1 = 1'b1;
      t = cyc;
      exp1_q.push_back('{32'h0000_A5C3, t + 1 + LAT1});
      exp1_q.push_back('{32'h0000_0F0F, t + 1 + LAT1 + 1 + LAT1});
      @(negedge clk);
      start1 = 1'b0;
      wait_rdy(1, LAT1 + 10, seen);
      model1_val = 16'h0F0F;
      drops = 0;
      seen = 1'b0;
      for (int i = 0; i < LAT1 + 10 && !seen; i++) begin
         @(negedge clk);
         if (i == 60) en1 = 1'b0;
         if (busy1 !== 1'b1) drops++;
         if (rdy1) seen = 1'b1;
      end
      vectors++;
      if (!seen || drops != 0) begin
         errors++;
         $display("FAIL continuous: second rdy=%b busy drops=%0d, required 1 and 0", seen, drops);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (rdy_cnt1 - r0 != 2 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL en_drop: %0d rdy pulses busy=%b, required 2 pulses busy=0",
                  rdy_cnt1 - r0, busy1);
      end
   endtask

   task automatic test_held_start;
      int t, r0;
      bit seen;
      logic [1:0] gap;
      @(negedge clk);
      model1_val = 16'h5AA5;
      r0 = rdy_cnt1;
      start1 = 1'b1;
      t = cyc;
      exp1_q.push_back('{32'h0000_5AA5, t + 1 + LAT1});
      exp1_q.push_back('{32'h0000_5AA5, t + 1 + LAT1 + 2 + LAT1});
      wait_rdy(1, LAT1 + 10, seen);
      @(negedge clk);
      gap[1] = busy1;
      @(negedge clk);
      gap[0] = busy1;
      vectors++;
      if (gap !== 2'b01) begin
         errors++;
         $display("FAIL held_gap: busy after DONE=%b, required 01", gap);
      end
      repeat (3) @(negedge clk);
      start1 = 1'b0;
      wait_rdy(1, LAT1 + 10, seen);
      repeat (20) @(negedge clk);
      vectors++;
      if (rdy_cnt1 - r0 != 2 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL held_start: %0d rdy pulses busy=%b, required 2 pulses busy=0",
                  rdy_cnt1 - r0, busy1);
      end
   endtask

   task automatic test_reset_mid;
      int t, r0;
      bit seen;
      @(negedge clk);
      model1_val = 16'hFFFF;
      r0 = rdy_cnt1;
      start1 = 1'b1;
      t = cyc;
      exp1_q.push_back('{32'h0000_FFFF, t + 1 + LAT1});
      @(negedge clk);
      start1 = 1'b0;
      repeat (70) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      vectors++;
      if ({bus1.sw_load_n, bus1.sw_clk, bus1.sw_ce_n, busy1, rdy1} !== 5'b10100 || pout1 !== '0) begin
         errors++;
         $display("FAIL reset_mid: load_n,clk,ce_n,busy,rdy=%b P_out=%h, required 10100 and 0",
                  {bus1.sw_load_n, bus1.sw_clk, bus1.sw_ce_n, busy1, rdy1}, pout1);
      end
      exp1_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      vectors++;
      if (rdy_cnt1 != r0) begin
         errors++;
         $display("FAIL reset_mid_rdy: %0d rdy pulses, required 0", rdy_cnt1 - r0);
      end
      model1_val = 16'h3C5A;
      start1 = 1'b1;
      t = cyc;
      exp1_q.push_back('{32'h0000_3C5A, t + 1 + LAT1});
      @(negedge clk);
      start1 = 1'b0;
      wait_rdy(1, LAT1 + 10, seen);
      vectors++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_rescan: rdy not seen, required within %0d cycles", LAT1 + 10);
      end
   endtask

   task automatic test_wide;
      int t, rises0;
      bit seen;
      @(negedge clk);
      model2_val = 32'h8000_0001;
      rises0 = clk_rises2;
      start2 = 1'b1;
      t = cyc;
      exp2_q.push_back('{32'h8000_0001, t + 1 + LAT2});
      @(negedge clk);
      start2 = 1'b0;
      wait_rdy(2, LAT2 + 10, seen);
      @(posedge clk);
      #1;
      vectors++;
      if (!seen || clk_rises2 - rises0 != W2) begin
         errors++;
         $display("FAIL wide: rdy=%b sw_clk rises=%0d, required 1 and %0d",
                  seen, clk_rises2 - rises0, W2);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ignore_start();
      test_continuous();
      test_held_start();
      test_reset_mid();
      test_wide();
      repeat (5) @(negedge clk);
      vectors++;
      if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d scans outstanding, required 0/0",
                  exp1_q.size(), exp2_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
